pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 185 ++++++++++++++++++
 tb/tb_pwm_capture.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM width decoder: samples an asynchronous PWM line, measures its high time in
// generator ticks and recovers the 8-bit width code, with stuck-high and lost-signal flags.
module pwm_capture #(
    parameter int CLOCK_FREQUENCY  = 100_000_000,
    parameter int OUTPUT_FREQUENCY = 20_000
) (
    input  logic       i_fclk,
    input  logic       i_reset_n,
    input  logic       i_pwm_in,
    output logic [7:0] o_width,
    output logic       o_valid,
    output logic       o_stuck_high,
    output logic       o_lost
);

    localparam int DIV = CLOCK_FREQUENCY / OUTPUT_FREQUENCY;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST    = PW'(DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF    = PW'(DIV / 2);
    localparam logic [PW-1:0] PRESC_RESTART = PW'(1);
    localparam logic [8:0]    TICK_SAT      = 9'd256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          s2_dly_q, s2_dly_d;
    logic [1:0]    fill_q, fill_d;
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [8:0]    tick_q, tick_d;
    logic [7:0]    width_q, width_d;
    logic          valid_q, valid_d;
    logic          stuck_q, stuck_d;
    logic          lost_q, lost_d;

    logic          primed_s;
    logic          rise_s;
    logic          fall_s;
    logic [PW-1:0] presc_adv_s;
    logic [8:0]    tick_adv_s;
    logic          round_s;
    logic [9:0]    n_s;
    logic [7:0]    width_dec_s;

    // Edge detection, gated until the synchroniser holds three genuine samples after reset
    // so that a line already high at reset release is not mistaken for a rising edge.
    always_comb begin
        primed_s = (fill_q == 2'd3);
        rise_s   = primed_s & s2_q & ~s2_dly_q;
        fall_s   = primed_s & ~s2_q & s2_dly_q;
    end

    // Free-running advance of the prescaler/tick pair, tick saturating at 256.
    always_comb begin
        if (presc_q == PRESC_LAST) begin
            presc_adv_s = {PW{1'b0}};
            tick_adv_s  = (tick_q == TICK_SAT) ? TICK_SAT : tick_q + 9'd1;
        end else begin
            presc_adv_s = presc_q + PRESC_RESTART;
            tick_adv_s  = tick_q;
        end
    end

    // Width decode: round the measured high time to the nearest tick, then subtract one.
    always_comb begin
        round_s = (presc_q >= PRESC_HALF);
        n_s     = {1'b0, tick_q} + {9'd0, round_s};
        if (n_s == 10'd0) begin
            width_dec_s = 8'd0;
        end else if (n_s >= 10'd256) begin
            width_dec_s = 8'd255;
        end else begin
            width_dec_s = n_s[7:0] - 8'd1;
        end
    end

    // Next-state logic for the synchroniser, counters, FSM and registered outputs.
    // A restart loads 1 rather than 0 so the edge cycle itself is counted and the
    // counter value at decode equals the sampled high time.
    always_comb begin
        s1_d     = i_pwm_in;
        s2_d     = s1_q;
        s2_dly_d = s2_q;
        fill_d   = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
        state_d  = state_q;
        presc_d  = presc_adv_s;
        tick_d   = tick_adv_s;
        width_d  = width_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        lost_d   = lost_q;

        case (state_q)
            ST_IDLE: begin
                tick_d = 9'd0;
                if (rise_s) begin
                    state_d = ST_HIGH;
                    presc_d = PRESC_RESTART;
                end else begin
                    presc_d = {PW{1'b0}};
                end
            end
            ST_HIGH: begin
                if (fall_s) begin
                    state_d = ST_LOW;
                    presc_d = PRESC_RESTART;
                    tick_d  = 9'd0;
                    width_d = width_dec_s;
                    valid_d = 1'b1;
                    stuck_d = 1'b0;
                    lost_d  = 1'b0;
                end else if (tick_q == TICK_SAT) begin
                    presc_d = PRESC_RESTART;
                    tick_d  = 9'd0;
                    width_d = 8'd255;
                    valid_d = 1'b1;
                    stuck_d = 1'b1;
                    lost_d  = 1'b0;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    state_d = ST_HIGH;
                    presc_d = PRESC_RESTART;
                    tick_d  = 9'd0;
                end else if (tick_q == TICK_SAT) begin
                    presc_d = presc_q;
                    tick_d  = TICK_SAT;
                    width_d = 8'd0;
                    lost_d  = 1'b1;
                end else begin
                    state_d = ST_LOW;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = {PW{1'b0}};
                tick_d  = 9'd0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_fclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s2_dly_q <= 1'b0;
            fill_q   <= 2'd0;
            state_q  <= ST_IDLE;
            presc_q  <= {PW{1'b0}};
            tick_q   <= 9'd0;
            width_q  <= 8'd0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
            lost_q   <= 1'b1;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s2_dly_q <= s2_dly_d;
            fill_q   <= fill_d;
            state_q  <= state_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            width_q  <= width_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
            lost_q   <= lost_d;
        end
    end

    assign o_width      = width_q;
    assign o_valid      = valid_q;
    assign o_stuck_high = stuck_q;
    assign o_lost       = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with DIV = 10: widths, rounding, stuck-high, lost, reset mid-pulse.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwm;
    logic [7:0] o_width;
    logic       o_valid;
    logic       o_stuck_high;
    logic       o_lost;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int   ev_cyc[$];
    int   ev_w[$];
    logic ev_stuck[$];
    int   lost_cyc = -1;
    logic prev_lost;

    pwm_capture #(
        .CLOCK_FREQUENCY (1000),
        .OUTPUT_FREQUENCY(100)
    ) dut (
        .i_fclk      (clk),
        .i_reset_n   (rst_n),
        .i_pwm_in    (pwm),
        .o_width     (o_width),
        .o_valid     (o_valid),
        .o_stuck_high(o_stuck_high),
        .o_lost      (o_lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every o_valid cycle and the cycle o_lost rises, sampled on the falling edge.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_w.push_back(int'(o_width));
            ev_stuck.push_back(o_stuck_high);
        end
        if (o_lost === 1'b1 && prev_lost !== 1'b1) lost_cyc = cyc;
        prev_lost = o_lost;
    end

    task automatic clear_events();
        ev_cyc.delete();
        ev_w.delete();
        ev_stuck.delete();
    endtask

    task automatic hold(input logic v, input int n);
        pwm = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (o_width !== 8'd0) begin n_fail++; $display("FAIL reset_width: got %0d expected 0", o_width); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", o_valid); end
        n_checks++; if (o_stuck_high !== 1'b0) begin n_fail++; $display("FAIL reset_stuck: got %0b expected 0", o_stuck_high); end
        n_checks++; if (o_lost !== 1'b1) begin n_fail++; $display("FAIL reset_lost: got %0b expected 1", o_lost); end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++; if (o_lost !== 1'b1) begin n_fail++; $display("FAIL idle_lost: got %0b expected 1", o_lost); end
        n_checks++; if (ev_cyc.size() != 0) begin n_fail++; $display("FAIL idle_valid: got %0d pulses expected 0", ev_cyc.size()); end
    endtask

    task automatic test_min_width();
        int k;
        clear_events();
        for (int p = 0; p < 3; p++) begin
            hold(1'b1, 10);
            k = cyc + 1;
            hold(1'b0, 2550);
            n_checks++; if (ev_cyc.size() != 1) begin n_fail++; $display("FAIL min_count p%0d: got %0d pulses expected 1", p, ev_cyc.size()); end
            else begin
                n_checks++; if (ev_cyc[0] != k + 2) begin n_fail++; $display("FAIL min_latency p%0d: got cycle %0d expected %0d", p, ev_cyc[0], k + 2); end
                n_checks++; if (ev_w[0] != 0) begin n_fail++; $display("FAIL min_width p%0d: got %0d expected 0", p, ev_w[0]); end
            end
            n_checks++; if (o_lost !== 1'b0) begin n_fail++; $display("FAIL min_lost p%0d: got %0b expected 0", p, o_lost); end
            clear_events();
        end
    endtask

    task automatic test_mid_scale();
        int k;
        clear_events();
        for (int p = 0; p < 2; p++) begin
            hold(1'b1, 1280);
            k = cyc + 1;
            hold(1'b0, 1280);
            n_checks++; if (ev_cyc.size() != 1) begin n_fail++; $display("FAIL mid_count p%0d: got %0d pulses expected 1", p, ev_cyc.size()); end
            else begin
                n_checks++; if (ev_cyc[0] != k + 2) begin n_fail++; $display("FAIL mid_latency p%0d: got cycle %0d expected %0d", p, ev_cyc[0], k + 2); end
                n_checks++; if (ev_w[0] != 127) begin n_fail++; $display("FAIL mid_width p%0d: got %0d expected 127", p, ev_w[0]); end
                n_checks++; if (ev_stuck[0] !== 1'b0) begin n_fail++; $display("FAIL mid_stuck p%0d: got %0b expected 0", p, ev_stuck[0]); end
            end
            clear_events();
        end
    endtask

    task automatic test_rounding();
        int hi [5] = '{34, 35, 4, 15, 14};
        int exp_w [5] = '{2, 3, 0, 1, 0};
        clear_events();
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, hi[i]);
            hold(1'b0, 100);
            n_checks++; if (ev_cyc.size() != 1) begin n_fail++; $display("FAIL round_count h%0d: got %0d pulses expected 1", hi[i], ev_cyc.size()); end
            else begin
                n_checks++; if (ev_w[0] != exp_w[i]) begin n_fail++; $display("FAIL round_width h%0d: got %0d expected %0d", hi[i], ev_w[0], exp_w[i]); end
            end
            clear_events();
        end
    endtask

    task automatic test_stuck_high();
        int r;
        clear_events();
        r = cyc + 1;
        hold(1'b1, 6000);
        n_checks++; if (ev_cyc.size() != 2) begin n_fail++; $display("FAIL stuck_count: got %0d pulses expected 2", ev_cyc.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (ev_cyc[i] != r + 2 + 2560 * (i + 1)) begin n_fail++; $display("FAIL stuck_time%0d: got cycle %0d expected %0d", i, ev_cyc[i], r + 2 + 2560 * (i + 1)); end
                n_checks++; if (ev_w[i] != 255) begin n_fail++; $display("FAIL stuck_width%0d: got %0d expected 255", i, ev_w[i]); end
                n_checks++; if (ev_stuck[i] !== 1'b1) begin n_fail++; $display("FAIL stuck_flag%0d: got %0b expected 1", i, ev_stuck[i]); end
            end
        end
        n_checks++; if (o_stuck_high !== 1'b1) begin n_fail++; $display("FAIL stuck_level: got %0b expected 1", o_stuck_high); end
        n_checks++; if (o_lost !== 1'b0) begin n_fail++; $display("FAIL stuck_lost: got %0b expected 0", o_lost); end
        clear_events();
        hold(1'b0, 100);
        n_checks++; if (ev_cyc.size() != 1 || ev_w[0] != 87) begin n_fail++; $display("FAIL stuck_tail: got %0d pulses (first width %0d) expected 1 pulse width 87", ev_cyc.size(), (ev_w.size() > 0) ? ev_w[0] : -1); end
        n_checks++; if (o_stuck_high !== 1'b0) begin n_fail++; $display("FAIL stuck_clear: got %0b expected 0", o_stuck_high); end
        clear_events();
        hold(1'b1, 50);
        hold(1'b0, 100);
        n_checks++; if (ev_cyc.size() != 1 || ev_w[0] != 4) begin n_fail++; $display("FAIL stuck_after: got %0d pulses (first width %0d) expected 1 pulse width 4", ev_cyc.size(), (ev_w.size() > 0) ? ev_w[0] : -1); end
        clear_events();
    endtask

    task automatic test_lost();
        int k;
        clear_events();
        hold(1'b1, 1280);
        k = cyc + 1;
        hold(1'b0, 3000);
        n_checks++; if (ev_cyc.size() != 1) begin n_fail++; $display("FAIL lost_count: got %0d pulses expected 1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_w[0] != 127) begin n_fail++; $display("FAIL lost_pre_width: got %0d expected 127", ev_w[0]); end
        end
        n_checks++; if (lost_cyc != k + 2 + 2560) begin n_fail++; $display("FAIL lost_time: got cycle %0d expected %0d", lost_cyc, k + 2 + 2560); end
        n_checks++; if (o_lost !== 1'b1) begin n_fail++; $display("FAIL lost_level: got %0b expected 1", o_lost); end
        n_checks++; if (o_width !== 8'd0) begin n_fail++; $display("FAIL lost_width: got %0d expected 0", o_width); end
        clear_events();
        hold(1'b1, 20);
        hold(1'b0, 100);
        n_checks++; if (ev_cyc.size() != 1 || ev_w[0] != 1) begin n_fail++; $display("FAIL lost_recover: got %0d pulses (first width %0d) expected 1 pulse width 1", ev_cyc.size(), (ev_w.size() > 0) ? ev_w[0] : -1); end
        n_checks++; if (o_lost !== 1'b0) begin n_fail++; $display("FAIL lost_clear: got %0b expected 0", o_lost); end
        clear_events();
    endtask

    task automatic test_reset_mid_pulse();
        int k;
        clear_events();
        hold(1'b1, 200);
        rst_n = 1'b0;
        #1;
        n_checks++; if (o_lost !== 1'b1 || o_width !== 8'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got lost=%0b width=%0d valid=%0b expected 1/0/0", o_lost, o_width, o_valid); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 300);
        hold(1'b0, 100);
        n_checks++; if (ev_cyc.size() != 0) begin n_fail++; $display("FAIL rstmid_valid: got %0d pulses expected 0", ev_cyc.size()); end
        n_checks++; if (o_lost !== 1'b1) begin n_fail++; $display("FAIL rstmid_lost: got %0b expected 1", o_lost); end
        clear_events();
        hold(1'b1, 1280);
        k = cyc + 1;
        hold(1'b0, 100);
        n_checks++; if (ev_cyc.size() != 1) begin n_fail++; $display("FAIL rstmid_next_count: got %0d pulses expected 1", ev_cyc.size()); end
        else begin
            n_checks++; if (ev_w[0] != 127 || ev_cyc[0] != k + 2) begin n_fail++; $display("FAIL rstmid_next: got width %0d at cycle %0d expected 127 at %0d", ev_w[0], ev_cyc[0], k + 2); end
        end
        n_checks++; if (o_lost !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_lost: got %0b expected 0", o_lost); end
        clear_events();
    endtask

    initial begin
        test_reset();
        test_min_width();
        test_mid_scale();
        test_rounding();
        test_stuck_high();
        test_lost();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
